// File: rtl/pipe_pkg.sv
// Shared types and constants for the 8-bit pipeline: datapath widths,
// forwarding-source encodings and the EX/WB register bundle.
package pipe_pkg;

  localparam int DATA_W = 8;
  localparam int REG_AW = 3;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_WB = 2'b01,
    FWD_EX = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_bundle_t;

endpackage

// File: rtl/fwd_mux.sv
// Single-port operand bypass selector: EX result beats the WB register,
// which beats the register file read data.
module fwd_mux #(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int REG_AW = pipe_pkg::REG_AW
) (
  input  logic              ex_fwd,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              wb_fwd,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [REG_AW-1:0] rs,
  input  logic [DATA_W-1:0] rf_data,
  output logic [DATA_W-1:0] op,
  output logic [1:0]        sel
);
  import pipe_pkg::*;

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    sel = FWD_RF;
    op  = rf_data;
    if (ex_fwd && (ex_rd == rs)) begin
      sel = FWD_EX;
      op  = ex_result;
    end else if (wb_fwd && (wb_rd == rs)) begin
      sel = FWD_WB;
      op  = wb_data;
    end
  end

endmodule

// File: rtl/wb_forward_stage.sv
// EX/WB pipeline register, register-file write port, operand forwarding to
// decode and a retired-instruction counter.
module wb_forward_stage #(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int REG_AW = pipe_pkg::REG_AW,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              stall,
  input  logic              flush,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [DATA_W-1:0] rf_data_1,
  input  logic [DATA_W-1:0] rf_data_2,
  output logic              wb_reg_write,
  output logic [REG_AW-1:0] wb_reg_num,
  output logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] id_op_1,
  output logic [DATA_W-1:0] id_op_2,
  output logic [1:0]        fwd_sel_1,
  output logic [1:0]        fwd_sel_2,
  output logic [CNT_W-1:0]  retired
);
  import pipe_pkg::*;

  wb_bundle_t wb_q;
  logic       ex_fwd;
  logic       wb_fwd;

  // A flushed or empty EX slot enters WB as a bubble.
  assign ex_fwd = ex_valid & ex_reg_write & ~flush;
  assign wb_fwd = wb_q.valid & wb_q.reg_write;

  // NOTE: reset is synchronous and active-low, so it is only sampled inside the clocked branch.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
      wb_q    <= '0;
      retired <= '0;
    end else if (!stall) begin
      wb_q.valid     <= ex_valid & ~flush;
      wb_q.reg_write <= ex_fwd;
      wb_q.rd        <= ex_rd;
      wb_q.data      <= ex_result;
      if (wb_q.valid) retired <= retired + CNT_W'(1);
    end
  end

  // The register file commits on the same edge that retires the instruction.
  assign wb_reg_write = wb_fwd & ~stall;
  assign wb_reg_num   = wb_q.rd;
  assign wb_data      = wb_q.data;

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_1 (
    .ex_fwd   (ex_fwd),
    .ex_rd    (ex_rd),
    .ex_result(ex_result),
    .wb_fwd   (wb_fwd),
    .wb_rd    (wb_q.rd),
    .wb_data  (wb_q.data),
    .rs       (id_rs1),
    .rf_data  (rf_data_1),
    .op       (id_op_1),
    .sel      (fwd_sel_1)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_2 (
    .ex_fwd   (ex_fwd),
    .ex_rd    (ex_rd),
    .ex_result(ex_result),
    .wb_fwd   (wb_fwd),
    .wb_rd    (wb_q.rd),
    .wb_data  (wb_q.data),
    .rs       (id_rs2),
    .rf_data  (rf_data_2),
    .op       (id_op_2),
    .sel      (fwd_sel_2)
  );

endmodule

// File: tb/tb_wb_forward_stage.sv
// Self-checking bench for wb_forward_stage: directed cases with literal
// expectations, then randomized traffic against a behavioural pipeline model.
module tb_wb_forward_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic       ex_valid, ex_reg_write, stall, flush;
  logic [2:0] ex_rd, id_rs1, id_rs2;
  logic [7:0] ex_result, rf_data_1, rf_data_2;
  logic       wb_reg_write;
  logic [2:0] wb_reg_num;
  logic [7:0] wb_data, id_op_1, id_op_2, retired;
  logic [1:0] fwd_sel_1, fwd_sel_2;

  // The bench plays the register file.
  logic [7:0] rf_mem [8];
  assign rf_data_1 = rf_mem[id_rs1];
  assign rf_data_2 = rf_mem[id_rs2];

  // Model of the instruction sitting between EX and writeback.
  logic       m_valid, m_rw;
  logic [2:0] m_rd;
  logic [7:0] m_data;
  int         m_retired;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_forward_stage dut (
    .clk         (clk),
    .reset       (reset),
    .ex_valid    (ex_valid),
    .ex_reg_write(ex_reg_write),
    .ex_rd       (ex_rd),
    .ex_result   (ex_result),
    .stall       (stall),
    .flush       (flush),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .rf_data_1   (rf_data_1),
    .rf_data_2   (rf_data_2),
    .wb_reg_write(wb_reg_write),
    .wb_reg_num  (wb_reg_num),
    .wb_data     (wb_data),
    .id_op_1     (id_op_1),
    .id_op_2     (id_op_2),
    .fwd_sel_1   (fwd_sel_1),
    .fwd_sel_2   (fwd_sel_2),
    .retired     (retired)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Newest value of register rs as decode must see it: an in-flight EX write,
  // else the pending WB write, else the architectural register file.
  task automatic newest(input logic [2:0] rs, output logic [1:0] sel, output logic [7:0] val);
    if (ex_valid && ex_reg_write && !flush && ex_rd == rs) begin
      sel = 2'b10; val = ex_result;
    end else if (m_valid && m_rw && m_rd == rs) begin
      sel = 2'b01; val = m_data;
    end else begin
      sel = 2'b00; val = rf_mem[rs];
    end
  endtask

  task automatic compare_model();
    logic [1:0] s;
    logic [7:0] v;
    check("wb_reg_write", wb_reg_write, m_valid && m_rw && !stall);
    if (m_valid && m_rw) begin
      check("wb_reg_num", wb_reg_num, m_rd);
      check("wb_data", wb_data, m_data);
    end
    check("retired", retired, m_retired % 256);
    newest(id_rs1, s, v);
    check("fwd_sel_1", fwd_sel_1, s);
    check("id_op_1", id_op_1, v);
    newest(id_rs2, s, v);
    check("fwd_sel_2", fwd_sel_2, s);
    check("id_op_2", id_op_2, v);
  endtask

  // One rising edge; the model consumes the same inputs the DUT sampled.
  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      m_valid = 1'b0; m_rw = 1'b0; m_rd = '0; m_data = '0; m_retired = 0;
    end else if (!stall) begin
      if (m_valid && m_rw) rf_mem[m_rd] = m_data;
      if (m_valid) m_retired++;
      m_valid = ex_valid && !flush;
      m_rw    = ex_valid && ex_reg_write && !flush;
      m_rd    = ex_rd;
      m_data  = ex_result;
    end
    #1;
  endtask

  task automatic set_ex(input logic v, input logic rw, input logic [2:0] rd, input logic [7:0] res);
    ex_valid = v; ex_reg_write = rw; ex_rd = rd; ex_result = res;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int captured;
    for (int i = 0; i < 8; i++) rf_mem[i] = 8'(i);
    m_valid = 1'b0; m_rw = 1'b0; m_rd = '0; m_data = '0; m_retired = 0;
    reset = 1'b0; stall = 1'b0; flush = 1'b0; id_rs1 = 3'd0; id_rs2 = 3'd0;
    set_ex(1'b1, 1'b1, 3'd5, 8'hAA);
    @(negedge clk);

    // Reset with a valid EX op presented.
    tick();
    reset = 1'b1;
    set_ex(1'b0, 1'b0, 3'd0, 8'h00);
    #1;
    check("reset wb_reg_write", wb_reg_write, 1'b0);
    check("reset wb_data", wb_data, 8'h00);
    check("reset retired", retired, 8'h00);
    check("reset fwd_sel_1", fwd_sel_1, 2'b00);

    // Basic writeback of r3 <= 0x5A.
    set_ex(1'b1, 1'b1, 3'd3, 8'h5A);
    #1 tick();
    set_ex(1'b0, 1'b0, 3'd0, 8'h00);
    id_rs1 = 3'd1; id_rs2 = 3'd3;
    #1;
    check("basic wb_reg_write", wb_reg_write, 1'b1);
    check("basic wb_reg_num", wb_reg_num, 3'd3);
    check("basic wb_data", wb_data, 8'h5A);
    check("wbfwd rf_data_2", rf_data_2, 8'h03);
    check("wbfwd id_op_2", id_op_2, 8'h5A);
    check("wbfwd fwd_sel_2", fwd_sel_2, 2'b01);
    compare_model();

    // EX beats WB; a flush removes the EX candidate.
    set_ex(1'b1, 1'b1, 3'd3, 8'h77);
    id_rs1 = 3'd3;
    #1;
    check("expri id_op_1", id_op_1, 8'h77);
    check("expri fwd_sel_1", fwd_sel_1, 2'b10);
    flush = 1'b1;
    #1;
    check("flush id_op_1", id_op_1, 8'h5A);
    check("flush fwd_sel_1", fwd_sel_1, 2'b01);

    // Stall and flush together for two edges: everything holds.
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1 tick();
      check("stall wb_reg_write", wb_reg_write, 1'b0);
      check("stall wb_reg_num", wb_reg_num, 3'd3);
      check("stall wb_data", wb_data, 8'h5A);
      check("stall retired", retired, 8'h00);
      check("stall id_op_2", id_op_2, 8'h5A);
      compare_model();
    end
    stall = 1'b0;
    #1 tick();
    check("retire retired", retired, 8'h01);
    check("retire wb_reg_write", wb_reg_write, 1'b0);
    check("retire rf r3", rf_mem[3], 8'h5A);
    compare_model();

    // Reset mid-operation drops the pending write.
    flush = 1'b0;
    set_ex(1'b1, 1'b1, 3'd6, 8'h3C);
    #1 tick();
    check("pre-reset wb_reg_write", wb_reg_write, 1'b1);
    reset = 1'b0;
    #1 tick();
    reset = 1'b1;
    #1;
    check("midreset wb_reg_write", wb_reg_write, 1'b0);
    check("midreset retired", retired, 8'h00);
    check("midreset rf r6", rf_mem[6], 8'h06);

    // Counter wrap with interleaved bubbles.
    captured = 0;
    while (captured < 256) begin
      set_ex(1'($urandom_range(0, 2) != 0), 1'($urandom), 3'($urandom), 8'($urandom));
      flush  = ($urandom_range(0, 4) == 0);
      id_rs1 = 3'($urandom); id_rs2 = 3'($urandom);
      if (ex_valid && !flush) captured++;
      #1 compare_model();
      tick();
    end
    check("wrap retired 0xFF", retired, 8'hFF);
    set_ex(1'b0, 1'b0, 3'd0, 8'h00);
    flush = 1'b0;
    #1 tick();
    check("wrap retired 0x00", retired, 8'h00);
    compare_model();

    // Randomized traffic including stalls, flushes and occasional resets.
    for (int c = 0; c < 2000; c++) begin
      reset = ($urandom_range(0, 49) != 0);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 5) == 0);
      set_ex(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
             3'($urandom_range(0, 3)), 8'($urandom));
      id_rs1 = 3'($urandom_range(0, 3));
      id_rs2 = 3'($urandom_range(0, 3));
      #1 compare_model();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_forward_stage.md
# wb_forward_stage

EX/WB pipeline register and operand-forwarding unit for the 8-bit pipelined processor. Captures each executed instruction's result and destination, drives the register file write port (write number, write data, write enable) one cycle later, and supplies bypassed operands to the decode stage so ID never reads a stale register. Also keeps a retired-instruction counter for bring-up and debug.

## Interface
Parameters:
- DATA_W, 8, datapath width
- REG_AW, 3, register-number width (8 registers)
- CNT_W, 8, retired-instruction counter width

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-low
- ex_valid  input  1  EX stage holds a real instruction this cycle
- ex_reg_write  input  1  EX instruction writes a register
- ex_rd  input  REG_AW  EX destination register number
- ex_result  input  DATA_W  EX result
- stall  input  1  hold the WB register (no capture, no write, no retire)
- flush  input  1  kill the instruction currently in EX
- id_rs1, id_rs2  input  REG_AW  decode-stage read register numbers
- rf_data_1, rf_data_2  input  DATA_W  register file asynchronous read data for id_rs1/id_rs2
- wb_reg_write  output  1  register file write enable
- wb_reg_num  output  REG_AW  register file write number
- wb_data  output  DATA_W  register file write data
- id_op_1, id_op_2  output  DATA_W  forwarded operands to decode
- fwd_sel_1, fwd_sel_2  output  2  forwarding source: 00 regfile, 01 WB, 10 EX
- retired  output  CNT_W  count of instructions that completed WB

## Operation
- WB register fields: valid, reg_write, rd, data.
- Edge with reset=0: valid=0, reg_write=0, rd=0, data=0, retired=0. This overrides stall and flush.
- Edge with stall=1: all WB fields and retired hold their values.
- Edge otherwise: capture ex_valid & ~flush into valid, ex_valid & ex_reg_write & ~flush into reg_write, and ex_rd/ex_result into rd/data.
  - A flushed or invalid EX slot becomes a bubble: valid=0 and reg_write=0. rd and data may hold any value.
- wb_reg_write = valid & reg_write & ~stall. The register file writes at the same edge that retires the instruction.
- wb_reg_num = rd. wb_data = data.
- retired increments by 1, wrapping 0xFF to 0x00, at each non-reset edge where stall=0 and valid=1. Bubbles are not counted.
- Forwarding, evaluated independently for port n (1 and 2):
  - If ex_valid & ex_reg_write & ~flush & (ex_rd==id_rsn): select EX (10), id_op_n = ex_result.
  - Else if valid & reg_write & (rd==id_rsn): select WB (01), id_op_n = data.
  - Else select regfile (00), id_op_n = rf_data_n.
  - EX has priority over WB because it is the younger producer.
- Register 0 gets no special treatment; it is a general register and can be forwarded.
- Forwarding stays active while stall=1, so the held WB value keeps being bypassed.

## Timing
- Result latency: ex_result sampled at edge N appears on wb_data after edge N; the register file holds it after edge N+1.
- Forwarding and wb_* outputs are combinational from the WB register and current inputs. Nothing else is combinational.
- Simultaneous stall and flush: stall wins. The WB register holds, and the EX slot is not consumed.
- Reset asserted mid-operation: the pending WB write is dropped at that edge. wb_reg_write is 0 in the following cycle.
- Back-to-back writes to the same rd: on consecutive non-stalled edges, each result is written in order.

## Structure
- Shared package pipe_pkg:
  - DATA_W and REG_AW constants
  - the fwd_sel encodings FWD_RF, FWD_WB, FWD_EX
  - a wb_bundle struct (valid, reg_write, rd, data)
- One sub-module, fwd_mux: a single-port priority selector, instantiated twice, for id_rs1 and id_rs2.
- The WB register and counter live in the top module.

## Test plan
- Reset: drive reset=0 for one edge with ex_valid=1. Required after the edge: wb_reg_write=0, wb_data=0, retired=0, fwd_sel_1=00.
- Basic writeback: ex_valid=1, ex_reg_write=1, ex_rd=3, ex_result=0x5A. Required after one edge: wb_reg_write=1, wb_reg_num=3, wb_data=0x5A. Required after the next edge: retired=1.
- WB forward: with WB holding rd=3, data=0x5A, set id_rs2=3, rf_data_2=0x03, and no EX match. Required: id_op_2=0x5A, fwd_sel_2=01.
- EX priority: with WB holding rd=3, data=0x5A, set EX rd=3, result=0x77, id_rs1=3. Required: id_op_1=0x77, fwd_sel_1=10. If flush=1 instead, required: id_op_1=0x5A.
- Stall and flush together: set stall=1 and flush=1 for 2 cycles with a valid EX op. Required: WB fields unchanged, wb_reg_write=0, retired unchanged.
- Counter wrap: retire 256 valid instructions. Required: retired returns to 0x00. Interleaved bubbles must not increment the count.
